sha256_compress_ctrl: RTL and testbench

Sequencer for the SHA-256 compression function. It owns the eight working registers a..h and the 6-bit round counter. It pulls one message-schedule word W[t] per round from the upstream scheduler through a valid/ready handshake, applies the round datapath (Ch, Maj, Σ0, Σ1, K[t]) for 64 rounds, then adds the working registers into the chaining value and presents the 256-bit digest. It sits between the message scheduler and the top-level hash wrapper.

---
 rtl/sha256_compress_ctrl_pkg.sv | 78 +++++++
 rtl/sha256_round_dp.sv | 22 ++
 rtl/sha256_compress_ctrl.sv | 101 ++++++++++
 tb/tb_sha256_compress_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_compress_ctrl_pkg.sv
// Shared SHA-256 constants, types and round helper functions for the compression sequencer.
package sha256_compress_ctrl_pkg;

    localparam int           ROUNDS     = 64;
    localparam int           WORD_W     = 32;
    localparam logic [5:0]   LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [255:0] H_INIT     = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    // Working variables a..h; a sits in the top word, matching H0 in hash_in.
    typedef struct packed {
        word_t a, b, c, d, e, f, g, h;
    } work_t;

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch_func(input word_t e, input word_t f, input word_t g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic word_t maj_func(input word_t a, input word_t b, input word_t c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Word-wise modulo-2^32 addition of two packed H0..H7 vectors.
    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*WORD_W +: WORD_W] = x[i*WORD_W +: WORD_W] + y[i*WORD_W +: WORD_W];
        end
        return r;
    endfunction

    // Round constants K[0..63].
    function automatic word_t k_const(input logic [5:0] t);
        word_t k;
        k = '0;
        case (t)
            6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; 6'd63: k = 32'hc67178f2;
            default: k = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/sha256_round_dp.sv
// Combinational SHA-256 round: next a..h from the current a..h, W[t] and K[t].
module sha256_round_dp
    import sha256_compress_ctrl_pkg::*;
(
    input  work_t cur,
    input  word_t w,
    input  word_t k,
    output work_t nxt
);

    word_t t1;
    word_t t2;

    // Form T1/T2 and shift the working registers down by one position.
    always_comb begin
        t1  = cur.h + big_sigma1(cur.e) + ch_func(cur.e, cur.f, cur.g) + k + w;
        t2  = big_sigma0(cur.a) + maj_func(cur.a, cur.b, cur.c);
        nxt = '{a: t1 + t2, b: cur.a, c: cur.b, d: cur.c,
                e: cur.d + t1, f: cur.e, g: cur.f, h: cur.g};
    end

endmodule

// File: rtl/sha256_compress_ctrl.sv
// SHA-256 compression sequencer: owns a..h, H0..H7 and the round counter, pulls one W per round.
module sha256_compress_ctrl
    import sha256_compress_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] hash_in,
    input  logic         abort,
    input  logic         w_valid,
    input  logic [31:0]  w_data,
    output logic         w_ready,
    output logic [5:0]   round_idx,
    output logic         busy,
    output logic         done,
    output logic [255:0] hash_out
);

    state_t       state, state_nxt;
    work_t        work, work_nxt, work_rnd;
    logic [255:0] h_reg, h_nxt;
    logic [255:0] hash_nxt;
    logic [5:0]   idx, idx_nxt;
    logic         done_nxt;
    word_t        k_t;

    assign k_t = k_const(idx);

    sha256_round_dp u_round (
        .cur (work),
        .w   (w_data),
        .k   (k_t),
        .nxt (work_rnd)
    );

    // Handshake and status are pure decodes of the registered state.
    assign w_ready   = (state == ROUND);
    assign busy      = (state != IDLE);
    assign round_idx = idx;

    // Next-state, round sequencing and digest update.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_nxt = state;
        work_nxt  = work;
        h_nxt     = h_reg;
        idx_nxt   = idx;
        hash_nxt  = hash_out;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    h_nxt     = hash_in;
                    work_nxt  = hash_in;
                    idx_nxt   = '0;
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (w_valid) begin
                    work_nxt = work_rnd;
                    idx_nxt  = idx + 6'd1;   // wraps to 0 after round 63
                    if (idx == LAST_ROUND) begin
                        state_nxt = FINAL;
                    end
                end
            end
            FINAL: begin
                state_nxt = IDLE;
                if (!abort) begin
                    hash_nxt = add_words(h_reg, work);
                    done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, working, chaining and result registers; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            work     <= '0;
            h_reg    <= '0;
            idx      <= '0;
            hash_out <= '0;
            done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_nxt;
            work     <= work_nxt;
            h_reg    <= h_nxt;
            idx      <= idx_nxt;
            hash_out <= hash_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// Self-checking bench for sha256_compress_ctrl: reference SHA-256 model plus digest scoreboard.
module tb_sha256_compress_ctrl;

    localparam int EV_NONE  = 0;
    localparam int EV_ABORT = 1;
    localparam int EV_RESET = 2;
    localparam int EV_BUSY  = 3;

    localparam logic [255:0] H0_TB = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIGEST = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_DIGEST = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        int           msg;
        int           pct;
        bit           init_h;
        bit           has_ref;
        logic [255:0] ref_d;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         w_valid = 1'b0;
    logic [255:0] hash_in = '0;
    logic [31:0]  w_data = '0;
    logic         w_ready, busy, done;
    logic [5:0]   round_idx;
    logic [255:0] hash_out;

    int           n_checks = 0;
    int           n_pass = 0;
    logic [255:0] exp_q [$];
    logic [31:0]  blk [16];
    logic [31:0]  ws [64];
    logic [255:0] last_digest = '0;
    vec_t         vecs [4];

    sha256_compress_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hash_in   (hash_in),
        .abort     (abort),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_ready   (w_ready),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done),
        .hash_out  (hash_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference compression of the current schedule ws[] starting from chaining value hin.
    function automatic logic [255:0] model_compress(input logic [255:0] hin);
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + ws[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    // Message blocks: 0 "abc", 1/2 the two blocks of the 56-byte message, otherwise random.
    task automatic load_block(input int msg);
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        case (msg)
            0: begin blk[0] = 32'h61626380; blk[15] = 32'h00000018; end
            1: begin
                for (int i = 0; i < 14; i++) blk[i] = 32'h61626364 + 32'h01010101 * i;
                blk[14] = 32'h80000000;
            end
            2: blk[15] = 32'h000001c0;
            default: for (int i = 0; i < 16; i++) blk[i] = $urandom;
        endcase
        for (int t = 0; t < 16; t++) ws[t] = blk[t];
        for (int t = 16; t < 64; t++) begin
            ws[t] = ws[t-16] + (rr(ws[t-15], 7) ^ rr(ws[t-15], 18) ^ (ws[t-15] >> 3))
                  + ws[t-7] + (rr(ws[t-2], 17) ^ rr(ws[t-2], 19) ^ (ws[t-2] >> 10));
        end
    endtask

    // Start a block at the current negedge and feed W; returns at the done cycle,
    // or right after an injected abort/reset.
    task automatic run_block(input logic [255:0] hin, input int pct, input int evt, input int evt_t);
        int           acc = 0;
        int           idle = 0;
        int           cycles = -1;
        bit           hs_ok = 1'b1;
        bit           fired = 1'b0;
        logic [255:0] exp_d;
        exp_q.push_back(model_compress(hin));
        start = 1'b1; hash_in = hin; w_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; hash_in = ~hin;
        for (int cyc = 0; cyc < 400; cyc++) begin
            start = 1'b0;
            if (acc < 64) begin
                if (w_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || round_idx !== acc[5:0]
                    || hash_out !== last_digest) hs_ok = 1'b0;
                if (evt == EV_ABORT && acc == evt_t) begin
                    abort = 1'b1; w_valid = 1'b1; w_data = ws[acc];
                    @(negedge clk);
                    abort = 1'b0; w_valid = 1'b0;
                    check("abort_busy_drop", 256'({busy, w_ready, done}), '0);
                    check("abort_pre_handshake", 256'(hs_ok), 256'(1));
                    void'(exp_q.pop_back());
                    return;
                end
                if (evt == EV_RESET && acc == evt_t) begin
                    w_valid = 1'b1; w_data = ws[acc];
                    #2 rst_n = 1'b0;
                    #1 check("reset_outputs", 256'({busy, w_ready, done, round_idx}), '0);
                    check("reset_hash", hash_out, '0);
                    void'(exp_q.pop_back());
                    @(negedge clk);
                    rst_n = 1'b1; w_valid = 1'b0;
                    return;
                end
                if (evt == EV_BUSY && acc == evt_t && !fired) begin
                    start = 1'b1; hash_in = hin ^ {8{32'h5a5a5a5a}}; fired = 1'b1;
                end
                w_valid = ($urandom_range(99) < pct);
                w_data  = w_valid ? ws[acc] : $urandom;
                if (w_valid) acc++;
                else idle++;
            end else if (done === 1'b1) begin
                cycles = cyc;
                break;
            end else begin
                if (w_ready !== 1'b0 || busy !== 1'b1 || round_idx !== 6'd0 || hash_out !== last_digest) hs_ok = 1'b0;
                w_valid = 1'($urandom_range(1)); w_data = $urandom;
            end
            @(negedge clk);
        end
        w_valid = 1'b0;
        exp_d = exp_q.pop_front();
        check("handshake", 256'(hs_ok), 256'(1));
        check("latency", 256'(cycles), 256'(65 + idle));
        check("digest", hash_out, exp_d);
        last_digest = exp_d;
    endtask

    task automatic after_done();
        @(negedge clk);
        check("done_one_cycle", 256'({done, busy}), '0);
        check("hash_held_idle", hash_out, last_digest);
    endtask

    task automatic expect_quiet(input string nm, input int n);
        bit seen = 1'b0;
        bit held = 1'b1;
        for (int i = 0; i < n; i++) begin
            w_valid = 1'($urandom_range(1)); w_data = $urandom;
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            if (hash_out !== last_digest) held = 1'b0;
        end
        w_valid = 1'b0;
        check({nm, "_no_done"}, 256'(seen), '0);
        check({nm, "_hash_held"}, 256'(held), 256'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 100, 1'b1, 1'b1, ABC_DIGEST};
        vecs[1] = '{0, 50,  1'b1, 1'b1, ABC_DIGEST};
        vecs[2] = '{3, 70,  1'b0, 1'b0, '0};
        vecs[3] = '{3, 30,  1'b0, 1'b0, '0};

        // Reset values.
        @(negedge clk);
        check("reset_state", 256'({busy, w_ready, done, round_idx}), '0);
        check("reset_hash_out", hash_out, '0);
        rst_n = 1'b1;

        // start together with abort in IDLE: nothing begins.
        start = 1'b1; abort = 1'b1; hash_in = rand256();
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 256'({busy, w_ready, done}), '0);

        // Table: "abc" full rate and 50% backpressure, random blocks at mixed rates.
        for (int i = 0; i < 4; i++) begin
            load_block(vecs[i].msg);
            run_block(vecs[i].init_h ? H0_TB : rand256(), vecs[i].pct, EV_NONE, 0);
            if (vecs[i].has_ref) check("ref_digest", hash_out, vecs[i].ref_d);
            after_done();
        end

        // Two-block chaining, second start issued in the done cycle.
        load_block(1);
        run_block(H0_TB, 100, EV_NONE, 0);
        load_block(2);
        run_block(hash_out, 100, EV_NONE, 0);
        check("chain_ref_digest", hash_out, TWO_DIGEST);
        after_done();

        // Abort at round 30, then a clean block.
        load_block(0);
        run_block(H0_TB, 100, EV_ABORT, 30);
        expect_quiet("abort", 80);
        run_block(H0_TB, 100, EV_NONE, 0);
        check("post_abort_ref", hash_out, ABC_DIGEST);
        after_done();

        // Asynchronous reset at round 40.
        load_block(3);
        run_block(rand256(), 100, EV_RESET, 40);
        last_digest = '0;
        expect_quiet("reset", 80);

        // start pulsed mid-block with another chaining value is ignored.
        load_block(3);
        run_block(rand256(), 60, EV_BUSY, 10);
        after_done();

        check("scoreboard_drained", 256'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
